// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with lane steering and load extension
module load_store_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_off;
  logic        illegal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (req_funct3)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = req_addr[0];
      3'b010:         illegal = |req_addr[1:0];
      default:        illegal = 1'b1;
    endcase
    // unsigned widths only exist for loads
    if (req_we && req_funct3[2]) illegal = 1'b1;
  end

  always_comb begin
    case (req_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{lat_off, 3'b000} +: 8];
    ld_half = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (lat_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'b0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'b0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  assign stall = ((state == IDLE) && req_valid) || (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lat_funct3 <= 3'b000;
      lat_off    <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_be     <= 4'b0000;
      ld_valid   <= 1'b0;
      ld_data    <= 32'h0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              err   <= 1'b1;
              state <= RESP;
            end else begin
              lat_funct3 <= req_funct3;
              lat_off    <= req_addr[1:0];
              mem_req    <= 1'b1;
              mem_we     <= req_we;
              mem_addr   <= {req_addr[31:2], 2'b00};
              mem_wdata  <= wdata_c;
              mem_be     <= be_c;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (!mem_we) begin
              ld_valid <= 1'b1;
              ld_data  <= ld_ext;
            end
          end
        end
        RESP: begin
          ld_valid <= 1'b0;
          err      <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a behavioural model
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_ld;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_illegal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int n;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 1'b1;
    if (we && f3 >= 4) return 1'b1;
    n = 1 << f3[1:0];
    return (addr % n) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    if (f3[1:0] == 2'd0) return 4'(1 << (addr % 4));
    if (f3[1:0] == 2'd1) return 4'(3 << (addr % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    logic [31:0] v;
    bit sgn;
    sgn = (f3[2] == 1'b0);
    v = rd >> (8 * (addr % 4));
    if (f3[1:0] == 2'd0) begin
      v = v & 32'hFF;
      if (sgn && v >= 128) v = v - 32'd256;
    end else if (f3[1:0] == 2'd1) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32768) v = v - 32'd65536;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  // Entered just after a rising edge; leaves just after the rising edge that follows RESP.
  task automatic run_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly);
    bit ill;
    ill        = is_illegal(we, f3, addr);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    mem_ready  = 1'($urandom % 2);
    mem_rdata  = $urandom;
    @(negedge clk);
    check("stall_accept", stall, 1);
    check("mem_req_idle", mem_req, 0);
    check("err_idle", err, 0);
    if (ill) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom % 2);
      @(negedge clk);
      check("err_pulse", err, 1);
      check("err_stall", stall, 0);
      check("err_mem_req", mem_req, 0);
      check("err_ld_valid", ld_valid, 0);
      check("err_ld_data", ld_data, exp_ld);
    end else begin
      for (int i = 0; i <= dly; i++) begin
        @(posedge clk); #1;
        mem_ready = (i == dly);
        mem_rdata = (i == dly) ? rd : $urandom;
        @(negedge clk);
        check("busy_mem_req", mem_req, 1);
        check("busy_stall", stall, 1);
        check("busy_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("busy_be", mem_be, model_be(f3, addr));
        check("busy_we", mem_we, we);
        if (we) check("busy_wdata", mem_wdata, model_wdata(f3, wd));
        check("busy_ld_valid", ld_valid, 0);
      end
      @(posedge clk); #1;
      mem_ready = 1'($urandom % 2);
      mem_rdata = $urandom;
      if (!we) exp_ld = model_load(f3, addr, rd);
      @(negedge clk);
      check("resp_mem_req", mem_req, 0);
      check("resp_stall", stall, 0);
      check("resp_ld_valid", ld_valid, !we);
      check("resp_err", err, 0);
      check("resp_ld_data", ld_data, exp_ld);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    req_valid  = 1'b0;
    req_we     = 1'($urandom % 2);
    req_funct3 = 3'($urandom % 8);
    req_addr   = $urandom;
    mem_ready  = 1'($urandom % 2);
    @(negedge clk);
    check("idle_stall", stall, 0);
    check("idle_mem_req", mem_req, 0);
    check("idle_ld_valid", ld_valid, 0);
    check("idle_err", err, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_ld_valid", ld_valid, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_ld_data", ld_data, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_stall", stall, req_valid);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ready  = 1'b0;
    mem_rdata  = 32'h0;
    exp_ld     = 32'h0;
    #2;
    check_reset_values();
    req_valid = 1'b0;
    #1;
    check("rst_stall_low", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    run_req(1'b0, 3'b000, 32'h1003, 32'h0, 32'h80FF_0000, 0);
    check("lb_result", ld_data, 32'hFFFF_FF80);
    run_req(1'b0, 3'b101, 32'h2002, 32'h0, 32'h8001_1234, 2);
    check("lhu_result", ld_data, 32'h0000_8001);
    run_req(1'b0, 3'b010, 32'h2004, 32'h0, 32'h1357_9BDF, 1);
    check("lw_result", ld_data, 32'h1357_9BDF);
    run_req(1'b1, 3'b000, 32'h3001, 32'hDEAD_BEA5, 32'h0, 0);
    run_req(1'b1, 3'b001, 32'h3002, 32'hDEAD_BEA5, 32'h0, 1);
    check("store_keeps_ld", ld_data, 32'h1357_9BDF);
    run_req(1'b0, 3'b010, 32'h4002, 32'h0, 32'h0, 0);
    run_req(1'b1, 3'b001, 32'h4001, 32'h0, 32'h0, 0);
    run_req(1'b0, 3'b011, 32'h4000, 32'h0, 32'h0, 0);
    idle_cycle();

    // abandon an access mid-flight
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h5000;
    mem_ready  = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_mem_req", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    exp_ld    = 32'h0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();
    run_req(1'b0, 3'b010, 32'h6008, 32'h0, 32'hCAFE_F00D, 1);
    check("post_rst_lw", ld_data, 32'hCAFE_F00D);

    for (int k = 0; k < 300; k++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we   = 1'($urandom % 2);
      f3   = 3'($urandom % 8);
      addr = $urandom;
      if ($urandom % 3 != 0) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
      run_req(we, f3, addr, $urandom, $urandom, int'($urandom % 4));
      if ($urandom % 4 == 0) idle_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
